// File: rtl/motion_sequencer.sv
// Servo pose sequencer: fetches motion words from ROM, ramps three angle codes per frame and holds each pose.
// Targets are latched 3 cycles after START or STEP_PULSE. SEQ_SLEW_EN enables per-frame slew limiting; otherwise LOAD jumps to the target.
module motion_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter int          STEP_MAX   = 4,
    parameter logic [7:0]  HOME_ANGLE = 8'd90
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              LOOP,
    input  logic              FRAME_TICK,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [31:0]       ROM_DATA,
    output logic [7:0]        ANG1,
    output logic [7:0]        ANG2,
    output logic [7:0]        ANG3,
    output logic              BUSY,
    output logic              DONE,
    output logic              STEP_PULSE
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_MOVE, S_HOLD, S_DONE
    } state_t;

    localparam logic [7:0] STEP_C = 8'(STEP_MAX);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          ang1_q, ang1_d, ang2_q, ang2_d, ang3_q, ang3_d;
    logic [7:0]          tgt1_q, tgt1_d, tgt2_q, tgt2_d, tgt3_q, tgt3_d;
    logic [7:0]          hold_q, hold_d;
    logic                pulse_q, pulse_d;
    logic                at_tgt;

    // Move one angle code toward its target by at most STEP_C, never overshooting.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return (diff > STEP_C) ? cur + STEP_C : tgt;
        end
        diff = cur - tgt;
        return (diff > STEP_C) ? cur - STEP_C : tgt;
    endfunction

    assign at_tgt = (ang1_q == tgt1_q) && (ang2_q == tgt2_q) && (ang3_q == tgt3_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ang1_d  = ang1_q;
        ang2_d  = ang2_q;
        ang3_d  = ang3_q;
        tgt1_d  = tgt1_q;
        tgt2_d  = tgt2_q;
        tgt3_d  = tgt3_q;
        hold_d  = hold_q;
        pulse_d = 1'b0;
        if (STOP) begin
            state_d = S_IDLE;
            addr_d  = '0;
            hold_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_LOAD;
                S_LOAD: begin
                    if (ROM_DATA[7:0] == 8'd0) begin
                        if (LOOP) begin
                            addr_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        tgt1_d  = ROM_DATA[31:24];
                        tgt2_d  = ROM_DATA[23:16];
                        tgt3_d  = ROM_DATA[15:8];
                        hold_d  = ROM_DATA[7:0];
                        state_d = S_MOVE;
`ifdef SEQ_SLEW_EN
                        // angles ramp toward the new targets in MOVE
`else
                        ang1_d  = ROM_DATA[31:24];
                        ang2_d  = ROM_DATA[23:16];
                        ang3_d  = ROM_DATA[15:8];
`endif
                    end
                end
                S_MOVE: begin
                    // Arrival check takes priority so a tick in that cycle is not spent.
                    if (at_tgt) begin
                        state_d = S_HOLD;
                    end else if (FRAME_TICK) begin
                        ang1_d = slew(ang1_q, tgt1_q);
                        ang2_d = slew(ang2_q, tgt2_q);
                        ang3_d = slew(ang3_q, tgt3_q);
                    end
                end
                S_HOLD: begin
                    if (FRAME_TICK) begin
                        hold_d = hold_q - 8'd1;
                        if (hold_q == 8'd1) begin
                            pulse_d = 1'b1;
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ang1_q  <= HOME_ANGLE;
            ang2_q  <= HOME_ANGLE;
            ang3_q  <= HOME_ANGLE;
            tgt1_q  <= HOME_ANGLE;
            tgt2_q  <= HOME_ANGLE;
            tgt3_q  <= HOME_ANGLE;
            hold_q  <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ang1_q  <= ang1_d;
            ang2_q  <= ang2_d;
            ang3_q  <= ang3_d;
            tgt1_q  <= tgt1_d;
            tgt2_q  <= tgt2_d;
            tgt3_q  <= tgt3_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
        end
    end

    assign ROM_ADDR   = addr_q;
    assign ANG1       = ang1_q;
    assign ANG2       = ang2_q;
    assign ANG3       = ang3_q;
    assign BUSY       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign DONE       = (state_q == S_DONE);
    assign STEP_PULSE = pulse_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer: control-path vector table, pose/loop/stop/wrap sequences, angle-change scoreboard.
module tb_motion_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N, START, STOP, LOOP, FRAME_TICK;
    logic [7:0]  ROM_ADDR;
    logic [31:0] ROM_DATA;
    logic [7:0]  ANG1, ANG2, ANG3;
    logic        BUSY, DONE, STEP_PULSE;

    always #5 CLK = ~CLK;

    motion_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .LOOP(LOOP),
        .FRAME_TICK(FRAME_TICK), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
        .ANG1(ANG1), .ANG2(ANG2), .ANG3(ANG3),
        .BUSY(BUSY), .DONE(DONE), .STEP_PULSE(STEP_PULSE)
    );

`ifdef SEQ_SLEW_EN
    localparam int       RAMP_C   = 3;
    localparam int       RAMP_E   = 2;
    localparam bit [7:0] C_LOAD_A = 8'd90;
`else
    localparam int       RAMP_C   = 0;
    localparam int       RAMP_E   = 0;
    localparam bit [7:0] C_LOAD_A = 8'd100;
`endif

    logic [31:0] rom [256];
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] exp_q[$];
    logic [23:0] prev_ang = 24'd0;
    bit          sb_en = 1'b0;
    bit          watch = 1'b0;
    int          watch_bad = 0;
    int          pulse_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every change of the angle triple must match the next queued expectation.
    always @(negedge CLK) begin
        logic [23:0] cur;
        cur = {ANG1, ANG2, ANG3};
        if (sb_en && cur !== prev_ang) begin
            if (exp_q.size() == 0) check("sb_unexpected_change", 32'(cur), 32'(prev_ang));
            else                   check("sb_angles", 32'(cur), 32'(exp_q.pop_front()));
        end
        prev_ang = cur;
        if (STEP_PULSE === 1'b1) pulse_cnt++;
        if (watch && (DONE !== 1'b0 || BUSY !== 1'b1)) watch_bad++;
    end

    function automatic logic [31:0] pack(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] h);
        return {a, b, c, h};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tick_once();
        FRAME_TICK = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        FRAME_TICK = 1'b0;
    endtask

    task automatic start_pulse();
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        exp_q.delete();
        RST_N = 1'b0; START = 1'b0; STOP = 1'b0; LOOP = 1'b0; FRAME_TICK = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        sb_en = 1'b1;
    endtask

    task automatic stop_pulse();
        STOP = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        STOP = 1'b0;
    endtask

    typedef struct {
        logic       start, stop, loop, tick;
        logic       exp_busy, exp_done;
        logic [7:0] exp_addr;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        int   np;
        bit   wrap_done;

        for (int i = 0; i < 256; i++) rom[i] = 32'd0;

        // Reset state and idle frames
        do_reset();
        check("rst_ang1", 32'(ANG1), 32'd90);
        check("rst_ang2", 32'(ANG2), 32'd90);
        check("rst_ang3", 32'(ANG3), 32'd90);
        check("rst_addr", 32'(ROM_ADDR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_pulse", 32'(STEP_PULSE), 32'd0);
        pulse_cnt = 0;
        repeat (10) begin tick_once(); idle(3); end
        check("idle_pulses", 32'(pulse_cnt), 32'd0);
        check("idle_ang1", 32'(ANG1), 32'd90);
        check("idle_addr", 32'(ROM_ADDR), 32'd0);
        check("idle_busy", 32'(BUSY), 32'd0);

        // Control path vectors with ROM[0] an end marker
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 12; i++) begin
            START = vt[i].start; STOP = vt[i].stop; LOOP = vt[i].loop; FRAME_TICK = vt[i].tick;
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(vt[i].exp_busy));
            check($sformatf("vec%0d_done", i), 32'(DONE), 32'(vt[i].exp_done));
            check($sformatf("vec%0d_addr", i), 32'(ROM_ADDR), 32'(vt[i].exp_addr));
            check($sformatf("vec%0d_pulse", i), 32'(STEP_PULSE), 32'd0);
        end
        START = 1'b0; STOP = 1'b0; LOOP = 1'b0; FRAME_TICK = 1'b0;

        // Single pose then end marker, LOOP=0
        do_reset();
        rom[0] = pack(8'd100, 8'd90, 8'd80, 8'd3);
        rom[1] = 32'd0;
`ifdef SEQ_SLEW_EN
        exp_q.push_back({8'd94, 8'd90, 8'd86});
        exp_q.push_back({8'd98, 8'd90, 8'd82});
        exp_q.push_back({8'd100, 8'd90, 8'd80});
`else
        exp_q.push_back({8'd100, 8'd90, 8'd80});
`endif
        start_pulse();
        idle(3);
        check("c_load_ang1", 32'(ANG1), 32'(C_LOAD_A));
        check("c_load_busy", 32'(BUSY), 32'd1);
        check("c_load_addr", 32'(ROM_ADDR), 32'd0);
        repeat (RAMP_C) begin tick_once(); idle(1); end
        idle(2);
        pulse_cnt = 0;
        tick_once();
        check("c_hold_tick1", 32'(STEP_PULSE), 32'd0);
        idle(1);
        tick_once();
        check("c_hold_tick2", 32'(STEP_PULSE), 32'd0);
        idle(1);
        tick_once();
        check("c_hold_tick3_pulse", 32'(STEP_PULSE), 32'd1);
        check("c_addr_next", 32'(ROM_ADDR), 32'd1);
        idle(5);
        check("c_done", 32'(DONE), 32'd1);
        check("c_busy", 32'(BUSY), 32'd0);
        tick_once();
        idle(2);
        check("c_ang1", 32'(ANG1), 32'd100);
        check("c_ang2", 32'(ANG2), 32'd90);
        check("c_ang3", 32'(ANG3), 32'd80);
        check("c_pulse_count", 32'(pulse_cnt), 32'd1);
        check("c_sb_drained", 32'(exp_q.size()), 32'd0);

        // Same ROM with LOOP=1
        do_reset();
        LOOP = 1'b1;
`ifdef SEQ_SLEW_EN
        exp_q.push_back({8'd94, 8'd90, 8'd86});
        exp_q.push_back({8'd98, 8'd90, 8'd82});
        exp_q.push_back({8'd100, 8'd90, 8'd80});
`else
        exp_q.push_back({8'd100, 8'd90, 8'd80});
`endif
        start_pulse();
        idle(3);
        repeat (RAMP_C) begin tick_once(); idle(1); end
        idle(2);
        watch = 1'b1;
        tick_once(); idle(1);
        tick_once(); idle(1);
        tick_once();
        check("d_pulse1", 32'(STEP_PULSE), 32'd1);
        idle(3);
        check("d_addr_loop", 32'(ROM_ADDR), 32'd0);
        idle(5);
        tick_once(); idle(1);
        tick_once(); idle(1);
        tick_once();
        check("d_pulse2", 32'(STEP_PULSE), 32'd1);
        check("d_addr_after_refetch", 32'(ROM_ADDR), 32'd1);
        idle(1);
        watch = 1'b0;
        check("d_busy_done_stable", 32'(watch_bad), 32'd0);
        check("d_sb_drained", 32'(exp_q.size()), 32'd0);
        LOOP = 1'b0;
        stop_pulse();

        // STOP during HOLD of the second pose
        do_reset();
        rom[0] = pack(8'd90, 8'd90, 8'd90, 8'd1);
        rom[1] = pack(8'd98, 8'd90, 8'd90, 8'd5);
`ifdef SEQ_SLEW_EN
        exp_q.push_back({8'd94, 8'd90, 8'd90});
        exp_q.push_back({8'd98, 8'd90, 8'd90});
`else
        exp_q.push_back({8'd98, 8'd90, 8'd90});
`endif
        start_pulse();
        idle(5);
        tick_once();
        check("e_pose0_pulse", 32'(STEP_PULSE), 32'd1);
        check("e_pose0_addr", 32'(ROM_ADDR), 32'd1);
        idle(3);
        repeat (RAMP_E) begin tick_once(); idle(1); end
        idle(2);
        check("e_ang1_reached", 32'(ANG1), 32'd98);
        tick_once();
        check("e_hold_no_pulse", 32'(STEP_PULSE), 32'd0);
        idle(1);
        stop_pulse();
        check("e_stop_busy", 32'(BUSY), 32'd0);
        check("e_stop_done", 32'(DONE), 32'd0);
        check("e_stop_ang1", 32'(ANG1), 32'd98);
        check("e_stop_addr", 32'(ROM_ADDR), 32'd0);
        START = 1'b1; STOP = 1'b1; FRAME_TICK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check($sformatf("e_start_stop_busy%0d", i), 32'(BUSY), 32'd0);
        end
        START = 1'b0; STOP = 1'b0; FRAME_TICK = 1'b0;
        idle(2);
        check("e_frozen_ang1", 32'(ANG1), 32'd98);
        check("e_sb_drained", 32'(exp_q.size()), 32'd0);

        // 256 non-end entries: address wrap and ramp down to 0
        do_reset();
        sb_en = 1'b0;
        for (int i = 0; i < 255; i++) rom[i] = pack(8'd255, 8'd255, 8'd255, 8'd1);
        rom[255] = pack(8'd0, 8'd0, 8'd0, 8'd1);
        FRAME_TICK = 1'b1;
        start_pulse();
        np = 0;
        wrap_done = 1'b0;
        for (int c = 0; c < 8000 && !wrap_done; c++) begin
            @(negedge CLK);
            if (STEP_PULSE === 1'b1) begin
                np++;
                if (np == 255) check("f_addr_255", 32'(ROM_ADDR), 32'd255);
                if (np == 256) begin
                    check("f_addr_wrap", 32'(ROM_ADDR), 32'd0);
                    check("f_ang1_zero", 32'(ANG1), 32'd0);
                    check("f_ang2_zero", 32'(ANG2), 32'd0);
                    check("f_ang3_zero", 32'(ANG3), 32'd0);
                    wrap_done = 1'b1;
                end
            end
        end
        if (!wrap_done) check("f_wrap_timeout_pulses", 32'(np), 32'd256);
        FRAME_TICK = 1'b0;
        stop_pulse();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
